shape_select_ctrl: RTL and testbench

- Generates the 2-bit shape select that drives the display's shape multiplexer.
- Encoding: 00 cuadrado, 01 circulo, 10 recta. Code 11 is never produced.
- Takes two raw push-buttons (next / prev), synchronises and debounces them, and steps a target shape.
- Commits the target to the `selec` output only on a frame boundary, so the drawn figure never changes mid-frame.

---
 rtl/shape_select_ctrl.sv | 112 +++++++++++
 tb/tb_shape_select_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shape_select_ctrl.sv
// shape_select_ctrl: debounced next/prev buttons step a shape target that is committed to selec only on frame_start.
// Optional auto-advance every AUTO_FRAMES frames when built with SHAPE_AUTO_EN defined.
module shape_select_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic          s1_q, s2_q, deb_q, deb_last_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_last_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= btn_i;
            s2_q       <= s1_q;
            deb_last_q <= deb_q;
            if (s2_q != deb_q) begin
                if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    deb_q <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end
    assign press_o = deb_q & ~deb_last_q;
endmodule

module shape_select_ctrl #(
    parameter int DEB_CYCLES  = 500000
`ifdef SHAPE_AUTO_EN
    , parameter int AUTO_FRAMES = 120
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       frame_start,
`ifdef SHAPE_AUTO_EN
    input  logic       auto_mode,
`endif
    output logic [1:0] selec,
    output logic       pending,
    output logic       applied
);
    logic       next_ev, prev_ev, next_all;
    logic [1:0] target_q, target_d, selec_q;
    logic       pending_q, applied_q, differ;

    shape_select_deb #(.DEB_CYCLES(DEB_CYCLES)) u_next (
        .clk(clk), .reset(reset), .btn_i(btn_next), .press_o(next_ev));
    shape_select_deb #(.DEB_CYCLES(DEB_CYCLES)) u_prev (
        .clk(clk), .reset(reset), .btn_i(btn_prev), .press_o(prev_ev));

`ifdef SHAPE_AUTO_EN
    localparam int AW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
    logic [AW-1:0] auto_cnt_q;
    logic          auto_wrap;
    assign auto_wrap = auto_mode && frame_start && auto_cnt_q == AW'(AUTO_FRAMES - 1);
    always_ff @(posedge clk) begin
        if (reset || !auto_mode)
            auto_cnt_q <= '0;
        else if (frame_start)
            auto_cnt_q <= auto_wrap ? '0 : auto_cnt_q + AW'(1);
    end
    assign next_all = next_ev | auto_wrap;
`else
    assign next_all = next_ev;
`endif

    // Simultaneous next and prev cancel; code 11 is unreachable from either step.
    always_comb begin
        target_d = target_q;
        if (next_all && !prev_ev)
            target_d = target_q == 2'd2 ? 2'd0 : target_q + 2'd1;
        else if (prev_ev && !next_all)
            target_d = target_q == 2'd0 ? 2'd2 : target_q - 2'd1;
    end

    assign differ = target_q != selec_q;

    // Commit uses the pre-step target, so a press on a frame boundary waits one frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q  <= 2'd0;
            selec_q   <= 2'd0;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            target_q  <= target_d;
            selec_q   <= (frame_start && differ) ? target_q : selec_q;
            applied_q <= frame_start && differ;
            pending_q <= differ;
        end
    end

    assign selec   = selec_q;
    assign pending = pending_q;
    assign applied = applied_q;
endmodule

// File: tb/tb_shape_select_ctrl.sv
// tb_shape_select_ctrl: directed tests of shape_select_ctrl with DEB_CYCLES=4 (AUTO_FRAMES=3 when SHAPE_AUTO_EN).
module tb_shape_select_ctrl;
    logic       clk = 1'b0, reset = 1'b1, btn_next = 1'b0, btn_prev = 1'b0, frame_start = 1'b0;
    logic [1:0] selec;
    logic       pending, applied;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

`ifdef SHAPE_AUTO_EN
    logic auto_mode = 1'b0;
    shape_select_ctrl #(.DEB_CYCLES(4), .AUTO_FRAMES(3)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .frame_start(frame_start), .auto_mode(auto_mode),
        .selec(selec), .pending(pending), .applied(applied));
`else
    shape_select_ctrl #(.DEB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .frame_start(frame_start),
        .selec(selec), .pending(pending), .applied(applied));
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; frame_start = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic press(input bit nxt, input bit prv);
        btn_next = nxt; btn_prev = prv;
        repeat (8) step();
        btn_next = 1'b0; btn_prev = 1'b0;
        repeat (8) step();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            frame_start = (i % 20) == 10;
            step();
            checks++; if (selec !== 2'b00) begin failures++; $display("FAIL reset_selec cyc=%0d got=%b want=00", i, selec); end
            checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending cyc=%0d got=%b want=0", i, pending); end
            checks++; if (applied !== 1'b0) begin failures++; $display("FAIL reset_applied cyc=%0d got=%b want=0", i, applied); end
        end
        frame_start = 1'b0;
        btn_next = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        btn_next = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (12) step();
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_mid_deb_pending got=%b want=0", pending); end
        frame();
        checks++; if (applied !== 1'b0) begin failures++; $display("FAIL reset_mid_deb_applied got=%b want=0", applied); end
        checks++; if (selec !== 2'b00) begin failures++; $display("FAIL reset_mid_deb_selec got=%b want=00", selec); end
    endtask

    task automatic test_clean_press();
        do_reset();
        btn_next = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            frame_start = (i == 31);
            step();
            if (i == 7) begin
                checks++; if (pending !== 1'b0) begin failures++; $display("FAIL clean_pending_early got=%b want=0", pending); end
            end
            if (i == 8) begin
                checks++; if (pending !== 1'b1) begin failures++; $display("FAIL clean_pending_rise got=%b want=1", pending); end
            end
            if (i == 30) begin
                checks++; if (applied !== 1'b0 || selec !== 2'b00) begin failures++; $display("FAIL clean_before_commit applied=%b selec=%b want 0/00", applied, selec); end
            end
            if (i == 31) begin
                checks++; if (selec !== 2'b01) begin failures++; $display("FAIL clean_commit_selec got=%b want=01", selec); end
                checks++; if (applied !== 1'b1) begin failures++; $display("FAIL clean_commit_applied got=%b want=1", applied); end
            end
            if (i == 32) begin
                checks++; if (applied !== 1'b0) begin failures++; $display("FAIL clean_applied_pulse got=%b want=0", applied); end
                checks++; if (pending !== 1'b0) begin failures++; $display("FAIL clean_pending_fall got=%b want=0", pending); end
            end
        end
        frame_start = 1'b0;
        btn_next = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            btn_next = (i <= 8) ? ((((i - 1) / 2) % 2) == 0) : 1'b1;
            step();
            if (i <= 15) begin
                checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bounce_no_step cyc=%0d got=%b want=0", i, pending); end
            end else begin
                checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bounce_step got=%b want=1", pending); end
            end
        end
        frame();
        checks++; if (selec !== 2'b01 || applied !== 1'b1) begin failures++; $display("FAIL bounce_commit selec=%b applied=%b want 01/1", selec, applied); end
        repeat (20) step();
        frame();
        checks++; if (selec !== 2'b01 || applied !== 1'b0) begin failures++; $display("FAIL bounce_single selec=%b applied=%b want 01/0", selec, applied); end
        btn_next = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_wrap();
        do_reset();
        press(1'b1, 1'b0);
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL wrap_first_pending got=%b want=1", pending); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL wrap_pending got=%b want=0", pending); end
        frame();
        checks++; if (selec !== 2'b00 || applied !== 1'b0) begin failures++; $display("FAIL wrap_commit selec=%b applied=%b want 00/0", selec, applied); end
        press(1'b0, 1'b1);
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL prev_pending got=%b want=1", pending); end
        frame();
        checks++; if (selec !== 2'b10 || applied !== 1'b1) begin failures++; $display("FAIL prev_commit selec=%b applied=%b want 10/1", selec, applied); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn_next = 1'b1; btn_prev = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++; if (pending !== 1'b0) begin failures++; $display("FAIL both_pending cyc=%0d got=%b want=0", i, pending); end
        end
        btn_next = 1'b0; btn_prev = 1'b0;
        repeat (8) step();
        frame();
        checks++; if (selec !== 2'b00 || applied !== 1'b0) begin failures++; $display("FAIL both_commit selec=%b applied=%b want 00/0", selec, applied); end
        press(1'b1, 1'b0);
        btn_next = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            frame_start = (i == 7);
            step();
            if (i == 7) begin
                checks++; if (selec !== 2'b01 || applied !== 1'b1) begin failures++; $display("FAIL coincide_commit selec=%b applied=%b want 01/1", selec, applied); end
            end
            if (i == 8) begin
                checks++; if (pending !== 1'b1) begin failures++; $display("FAIL coincide_pending got=%b want=1", pending); end
            end
        end
        frame_start = 1'b0;
        btn_next = 1'b0;
        repeat (8) step();
        frame();
        checks++; if (selec !== 2'b10 || applied !== 1'b1) begin failures++; $display("FAIL coincide_next_frame selec=%b applied=%b want 10/1", selec, applied); end
    endtask

`ifdef SHAPE_AUTO_EN
    task automatic test_auto();
        logic [1:0] exp_sel [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic       exp_app [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        auto_mode = 1'b1;
        for (int p = 0; p < 7; p++) begin
            repeat (4) step();
            frame();
            checks++; if (selec !== exp_sel[p] || applied !== exp_app[p]) begin failures++; $display("FAIL auto_pulse%0d selec=%b applied=%b want %b/%b", p + 1, selec, applied, exp_sel[p], exp_app[p]); end
        end
        auto_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_back_to_back();
`ifdef SHAPE_AUTO_EN
        test_auto();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
